// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern scanner.
// Holds the controller state encoding, default geometry and the
// power-on pattern configuration used by seq_scan_ctrl.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_PAT_MAX = 8;
  localparam int DEF_CNT_W   = 5;

  // Power-on pattern 1-0-1-1-0 (bit 0 is the most recent serial bit).
  localparam logic [7:0] DEF_PATTERN = 8'b0001_0110;
  localparam logic [3:0] DEF_LEN     = 4'd5;

  // res_first value reported when the word produced zero matches.
  localparam logic [4:0] NO_HIT = 5'h1F;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Handshake/bus bundle for seq_scan_ctrl.
//   cfg_*  : pattern/length write strobe and error pulse
//   in_*   : word input handshake
//   res_*  : result handshake with match count and first-match index
//   busy, hit : status
// slave  = scanner side, master = client side.
interface seq_scan_ctrl_if #(
  parameter int WORD_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 5
);
  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic               cfg_err;
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               busy;
  logic               hit;
  logic               res_valid;
  logic               res_ready;
  logic [CNT_W-1:0]   res_count;
  logic [4:0]         res_first;

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, in_valid, in_data, res_ready,
    output cfg_err, in_ready, busy, hit, res_valid, res_count, res_first
  );

  modport master (
    output cfg_we, cfg_pattern, cfg_len, in_valid, in_data, res_ready,
    input  cfg_err, in_ready, busy, hit, res_valid, res_count, res_first
  );
endinterface

// File: rtl/seq_match_core.sv
// Serial history register with masked pattern compare.
//   clk, rst : clock, asynchronous active-high reset
//   bit_in   : serial bit consumed this cycle (qualified by en)
//   en       : consume bit_in at the next edge
//   clr      : start of a new word; forget all history
//   pattern  : match pattern, bit 0 = most recent bit
//   len      : number of pattern bits that take part in the compare
//   match    : combinational; the bit being consumed completes a match
module seq_match_core #(
  parameter int PAT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               en,
  input  logic               clr,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [3:0]         len,
  output logic               match
);

  logic [PAT_MAX-2:0] hist;
  logic [PAT_MAX-1:0] nxt;
  logic [PAT_MAX-1:0] mask;
  logic [3:0]         fill;

  // The compare window includes the bit being consumed right now.
  assign nxt = {hist, bit_in};

  always_comb begin
    mask = '0;
    for (int k = 0; k < PAT_MAX; k++) begin
      mask[k] = (len > 4'(k));
    end
  end

  // fill tracks how many bits of this word are already in hist, so a
  // pattern of zeros cannot match against cleared history.
  assign match = en && (({1'b0, fill} + 5'd1) >= {1'b0, len}) &&
                 (((nxt ^ pattern) & mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else if (en && (fill < 4'(PAT_MAX))) begin
      fill <= fill + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hist <= '0;
    end else if (en) begin
      hist <= nxt[PAT_MAX-2:0];
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-serial pattern scanner.
// Accepts a WORD_W-bit word, shifts it out MSB first one bit per cycle,
// counts (overlapping) matches against the configured pattern and reports
// the count and the index of the first completing bit.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_scan_ctrl_if.slave (cfg, input word, result, status)
module seq_scan_ctrl import seq_pkg::*; #(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int PAT_MAX = DEF_PAT_MAX,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst,
  seq_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_e             state;
  logic [WORD_W-1:0]  word;
  logic [IDX_W-1:0]   idx;
  logic [PAT_MAX-1:0] pat;
  logic [3:0]         len;
  logic [CNT_W-1:0]   count;
  logic [4:0]         first;
  logic               hit_r;
  logic               err_r;
  logic               match;
  logic               accept;
  logic               shifting;
  logic               cfg_ok;

  assign accept   = (state == ST_IDLE) && bus.in_valid;
  assign shifting = (state == ST_SHIFT);
  assign cfg_ok   = (state == ST_IDLE) && (bus.cfg_len != 4'd0) &&
                    (bus.cfg_len <= 4'(PAT_MAX));

  seq_match_core #(.PAT_MAX(PAT_MAX)) u_core (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (word[WORD_W-1]),
    .en      (shifting),
    .clr     (accept),
    .pattern (pat),
    .len     (len),
    .match   (match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pat   <= PAT_MAX'(DEF_PATTERN);
      len   <= DEF_LEN;
      count <= '0;
      first <= NO_HIT;
      idx   <= '0;
      hit_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      hit_r <= match;
      err_r <= bus.cfg_we && !cfg_ok;
      // A word accepted on this same edge scans with the new config,
      // since the first compare happens on the following edge.
      if (bus.cfg_we && cfg_ok) begin
        pat <= bus.cfg_pattern;
        len <= bus.cfg_len;
      end
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            count <= '0;
            first <= NO_HIT;
            idx   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          idx <= idx + 1'b1;
          if (match) begin
            count <= count + 1'b1;
            if (first == NO_HIT) first <= 5'(idx);
          end
          if (idx == LAST_IDX) state <= ST_REPORT;
        end
        ST_REPORT: begin
          if (bus.res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word shifter is pure data; state gating makes its reset value moot.
  always_ff @(posedge clk) begin
    if (accept) begin
      word <= bus.in_data;
    end else if (shifting) begin
      word <= {word[WORD_W-2:0], 1'b0};
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.res_valid = (state == ST_REPORT);
  assign bus.res_count = count;
  assign bus.res_first = first;
  assign bus.hit       = hit_r;
  assign bus.cfg_err   = err_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  seq_scan_ctrl_if #(.WORD_W(16), .PAT_MAX(8), .CNT_W(5)) bus ();

  seq_scan_ctrl #(.WORD_W(16), .PAT_MAX(8), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input string tag, input logic [7:0] p, input logic [3:0] l,
                           input logic exp_err);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    tick();
    bus.cfg_we = 1'b0;
    chk({tag, ".err"}, 32'(bus.cfg_err), 32'(exp_err));
  endtask

  // Scan one word; optional config on the accept edge, optional illegal
  // config write injected mid-SHIFT, optional result back-pressure.
  task automatic run_word(input string tag, input logic [15:0] d,
                          input logic do_cfg, input logic [7:0] p, input logic [3:0] l,
                          input int inj_at, input int stall,
                          input int exp_cnt, input int exp_first, input logic [15:0] exp_mask);
    int cyc;
    logic [15:0] mask;
    logic [4:0] cnt0;
    logic [4:0] first0;
    mask = '0;
    chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (do_cfg) begin
      bus.cfg_we      = 1'b1;
      bus.cfg_pattern = p;
      bus.cfg_len     = l;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (bus.hit && cyc <= 16) mask[cyc-1] = 1'b1;
      if (inj_at > 0 && cyc == inj_at + 1) begin
        bus.cfg_we = 1'b0;
        chk({tag, ".shift_err"}, 32'(bus.cfg_err), 32'd1);
      end
      if (inj_at > 0 && cyc == inj_at) begin
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = 8'h05;
        bus.cfg_len     = 4'd3;
      end
      if (bus.res_valid) break;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'd16);
    chk({tag, ".cnt"}, 32'(bus.res_count), 32'(exp_cnt));
    chk({tag, ".first"}, 32'(bus.res_first), 32'(exp_first));
    chk({tag, ".hits"}, 32'(mask), 32'(exp_mask));
    cnt0   = bus.res_count;
    first0 = bus.res_first;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1234;
      tick();
      chk({tag, ".hold_cnt"}, 32'(bus.res_count), 32'(cnt0));
      chk({tag, ".hold_first"}, 32'(bus.res_first), 32'(first0));
      chk({tag, ".hold_vld"}, 32'(bus.res_valid), 32'd1);
      chk({tag, ".hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, ".done_vld"}, 32'(bus.res_valid), 32'd0);
    chk({tag, ".done_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    n_chk = 0;
    n_bad = 0;
    rst             = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.res_ready   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst.hit", 32'(bus.hit), 32'd0);
    chk("rst.cfg_err", 32'(bus.cfg_err), 32'd0);
    chk("rst.count", 32'(bus.res_count), 32'd0);
    chk("rst.first", 32'(bus.res_first), 32'h1F);

    // Default pattern 10110 on 0101_0110_0011_1001: single match ending at bit 7.
    run_word("def5639", 16'h5639, 1'b0, 8'h00, 4'd0, 0, 0, 1, 7, 16'h0080);
    // Config write during SHIFT is rejected; word still uses default config.
    run_word("shiftcfg", 16'h5639, 1'b0, 8'h00, 4'd0, 3, 0, 1, 7, 16'h0080);
    // Illegal lengths in IDLE are rejected; config unchanged.
    cfg_write("len0", 8'h05, 4'd0, 1'b1);
    cfg_write("len9", 8'h05, 4'd9, 1'b1);
    run_word("oldcfg", 16'h5639, 1'b0, 8'h00, 4'd0, 0, 0, 1, 7, 16'h0080);
    // Pattern 101 on AAAA: overlapping matches at bits 2,4,...,14.
    cfg_write("len3", 8'h05, 4'd3, 1'b0);
    run_word("aaaa", 16'hAAAA, 1'b0, 8'h00, 4'd0, 0, 0, 7, 2, 16'h5554);
    // Config change on the accept edge applies to that word.
    run_word("ffff", 16'hFFFF, 1'b1, 8'h01, 4'd1, 0, 0, 16, 0, 16'hFFFF);
    run_word("zero", 16'h0000, 1'b0, 8'h00, 4'd0, 0, 0, 0, 31, 16'h0000);
    // Back-pressure on the result for 5 cycles.
    run_word("stall", 16'h00F0, 1'b0, 8'h00, 4'd0, 0, 5, 4, 8, 16'h0F00);

    // Reset in the middle of SHIFT (after bits 0..7 consumed).
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5639;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk("mid.busy", 32'(bus.busy), 32'd0);
    chk("mid.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid.res_valid", 32'(bus.res_valid), 32'd0);
    tick();
    rst = 1'b0;
    chk("mid.count", 32'(bus.res_count), 32'd0);
    chk("mid.first", 32'(bus.res_first), 32'h1F);
    chk("mid.hit", 32'(bus.hit), 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.res_valid) seen++;
    end
    chk("mid.no_res", 32'(seen), 32'd0);
    // Reset restored the default pattern; next word scans normally.
    run_word("post_rst", 16'h5639, 1'b0, 8'h00, 4'd0, 0, 0, 1, 7, 16'h0080);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameters SHALL be: WORD_W, 16, bits per scanned word; PAT_MAX, 8, max pattern length; CNT_W, 5, hit-count width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cfg_we  in  1  pattern/length write strobe.
REQ-005 cfg_pattern  in  PAT_MAX  pattern; bit 0 = last serial bit.
REQ-006 cfg_len  in  4  pattern length, legal 1..PAT_MAX.
REQ-007 cfg_err  out  1  one-cycle pulse on rejected config write.
REQ-008 in_valid / in_ready  in / out  1 / 1  word handshake.
REQ-009 in_data  in  WORD_W  word, scanned MSB first.
REQ-010 busy  out  1  high in SHIFT or REPORT.
REQ-011 hit  out  1  registered one-cycle pulse per pattern match.
REQ-012 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-013 res_count  out  CNT_W  matches in the word.
REQ-014 res_first  out  5  bit index (0 = MSB) completing first match; 5'h1F = none.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT, REPORT.
REQ-016 IDLE: in_ready=1; word accepted on in_valid&&in_ready edge; word captured, history, bit index, count cleared, res_first=1F; next SHIFT.
REQ-017 SHIFT: in_ready=0; one bit consumed per cycle, bit i = in_data[WORD_W-1-i], i=0..WORD_W-1; no stalls.
REQ-018 Match at bit i SHALL require i+1 >= cfg_len and last cfg_len consumed bits == cfg_pattern[cfg_len-1:0]; overlapping matches count.
REQ-019 On match: count increments; hit high the cycle after the consuming edge; res_first set to i if still 1F.
REQ-020 Edge consuming bit WORD_W-1 SHALL move to REPORT with res_valid=1, res_count/res_first final (last-bit match included); accept-to-res_valid latency WORD_W cycles.
REQ-021 REPORT: res_valid, res_count, res_first held stable until res_valid&&res_ready edge, then IDLE; in_ready=1 no earlier than cycle after.
REQ-022 cfg_we in IDLE with legal cfg_len SHALL update pattern/length at that edge; a word accepted the same edge uses the new config.
REQ-023 cfg_we outside IDLE, or cfg_len 0 or >PAT_MAX, SHALL leave config unchanged and pulse cfg_err next cycle.
REQ-024 History SHALL not carry across words; count cannot overflow (max WORD_W=16 < 2^CNT_W).

Reset
REQ-025 rst SHALL force IDLE, pattern 5'b10110, len 5, count 0, res_first 1F, and hit, cfg_err, res_valid, busy low, in_ready high after release.
REQ-026 rst mid-SHIFT/REPORT SHALL discard word and result immediately; no res_valid produced.

Structure
REQ-027 Package seq_pkg SHALL hold state enum, WORD_W, PAT_MAX, default pattern/length constants.
REQ-028 Sub-module seq_match_core SHALL contain history shift register and masked compare (inputs bit, en, clr, pattern, len; output match).

Verification
REQ-029 Default config, in_data=16'h5639 -> one hit pulse, res_count=1, res_first=7, res_valid 16 cycles after accept.
REQ-030 Pattern 3'b101 len 3, in_data=16'hAAAA -> res_count=7, res_first=2, hit on bits 2,4,..,14.
REQ-031 Pattern 1 len 1, 16'hFFFF -> res_count=16, res_first=0; 16'h0000 -> res_count=0, res_first=1F.
REQ-032 res_ready low 5 cycles in REPORT -> outputs stable, in_ready=0 with in_valid high, no second accept.
REQ-033 cfg_we in SHIFT, and cfg_len=0 in IDLE -> cfg_err pulse each, subsequent word scans with old config.
REQ-034 rst asserted at bit 8 -> outputs at reset values, no res_valid; next word scans normally.
